// File: rtl/kgp_risc_multicycle.sv
// kgp_risc_multicycle: multi-cycle KGP-RISC core with req/ack memories, timeout, halt/illegal detection
module kgp_risc_multicycle #(
    parameter int          AW         = 11,
    parameter int          NREGS      = 32,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          WAIT_LIMIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    input  logic [4:0]    show_index,
    output logic [31:0]   reg_return,
    output logic          halted,
    output logic          illegal,
    output logic          bus_err,
    output logic [31:0]   retired
);
    localparam logic [5:0] OP_ALU = 6'd0, OP_ADDI = 6'd1, OP_LW = 6'd2, OP_SW = 6'd3, OP_BR = 6'd4, OP_HALT = 6'h3f;
    localparam logic [31:0] IMPL = NREGS >= 32 ? 32'hFFFF_FFFF : 32'((64'd1 << NREGS) - 64'd1);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state, state_n;

    logic [31:0] pc, ir, a, b, y, alu, sra, imm, target, wcnt;
    logic [31:0] regs [32];
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, shamt;
    logic        legal, taken, timeout, i_wait, d_wait;

    assign op         = ir[31:26];
    assign rs         = ir[25:21];
    assign rt         = ir[20:16];
    assign shamt      = ir[10:6];
    assign funct      = ir[5:0];
    assign imm        = {{16{ir[15]}}, ir[15:0]};
    assign target     = {17'd0, ir[20:6]};
    assign legal      = op == OP_ALU ? funct <= 6'd5 : op == OP_BR ? funct <= 6'd2 :
                        op inside {OP_ADDI, OP_LW, OP_SW, OP_HALT};
    assign taken      = funct == 6'd0 || (funct == 6'd1 ? a == 32'd0 : a[31]);
    assign sra        = $signed(a) >>> shamt;
    assign alu        = op == OP_ADDI ? a + imm : op != OP_ALU ? b + imm :
                        funct == 6'd0 ? a + b : funct == 6'd1 ? a - b :
                        funct == 6'd2 ? a & b : funct == 6'd3 ? a ^ b :
                        funct == 6'd4 ? a << shamt : sra;
    assign timeout    = wcnt == 32'(WAIT_LIMIT - 1);
    assign i_wait     = imem_req && !imem_ack;
    assign d_wait     = dmem_req && !dmem_ack;
    assign imem_req   = state == FETCH;
    assign imem_addr  = pc[AW-1:0];
    assign dmem_req   = state == MEM;
    assign dmem_we    = dmem_req && op == OP_SW;
    assign dmem_addr  = y[AW-1:0];
    assign dmem_wdata = a;
    assign halted     = state == HALT;
    assign reg_return = IMPL[show_index] ? regs[show_index] : 32'd0;

    // state register; reset aborts any pending handshake
    always_ff @(posedge clk)
        state <= rst ? FETCH : state_n;

    // next-state: memory states stall until ack or timeout
    always_comb begin
        state_n = state;
        case (state)
            FETCH:   state_n = imem_ack ? DECODE : timeout ? HALT : FETCH;
            DECODE:  state_n = EXEC;
            EXEC:    state_n = !legal || op == OP_HALT ? HALT : op == OP_BR ? FETCH :
                               (op == OP_LW || op == OP_SW) ? MEM : WB;
            MEM:     state_n = dmem_ack ? (dmem_we ? FETCH : WB) : timeout ? HALT : MEM;
            WB:      state_n = FETCH;
            default: state_n = HALT;
        endcase
    end

    // datapath: IR/operand latches, PC, register file, status and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            y       <= '0;
            wcnt    <= '0;
            retired <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            wcnt <= (i_wait || d_wait) ? wcnt + 32'd1 : 32'd0;
            if ((i_wait || d_wait) && timeout) bus_err <= 1'b1;
            if (imem_req && imem_ack) ir <= imem_rdata;
            if (state == DECODE) begin
                a <= IMPL[rs] ? regs[rs] : 32'd0;
                b <= IMPL[rt] ? regs[rt] : 32'd0;
            end
            if (state == EXEC) begin
                y <= alu;
                if (!legal) illegal <= 1'b1;
                else if (op == OP_BR || op == OP_HALT) begin
                    pc      <= op == OP_BR && taken ? target : pc + 32'd1;
                    retired <= retired + 32'd1;
                end
            end
            if (dmem_req && dmem_ack) begin
                if (dmem_we) begin
                    pc      <= pc + 32'd1;
                    retired <= retired + 32'd1;
                end else y <= dmem_rdata;
            end
            if (state == WB) begin
                if (IMPL[rs]) regs[rs] <= y;
                pc      <= pc + 32'd1;
                retired <= retired + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_kgp_risc_multicycle.sv
// tb_kgp_risc_multicycle: vector table, corner sequences and random programs against an ISA model
module tb_kgp_risc_multicycle;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal, bus_err;
    logic [10:0] imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, reg_return, retired;
    logic [4:0]  show_index = 5'd0;

    kgp_risc_multicycle dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .show_index(show_index), .reg_return(reg_return),
        .halted(halted), .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [2048];
    logic [31:0] dmem [2048];
    logic [31:0] dm_init [2048];
    int imin = 0, imax = 0, dmin = 0, dmax = 0;
    bit i_never = 1'b0, d_never = 1'b0;
    int icnt = 0, dcnt = 0, ilat = 0, dlat = 0;
    int checks = 0, errors = 0;
    int dreq_n, dbad, unstable;
    logic [10:0] want_addr = 11'd0;

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign imem_ack   = imem_req && !i_never && icnt >= ilat;
    assign dmem_ack   = dmem_req && !d_never && dcnt >= dlat;

    // memory responders: latency picked per request, stores land on the ack edge
    always @(posedge clk) begin
        icnt <= (rst || !imem_req || imem_ack) ? 0 : icnt + 1;
        dcnt <= (rst || !dmem_req || dmem_ack) ? 0 : dcnt + 1;
        if (rst || !imem_req || imem_ack) ilat <= int'($urandom_range(imax, imin));
        if (rst || !dmem_req || dmem_ack) dlat <= int'($urandom_range(dmax, dmin));
        if (rst) dmem <= dm_init;
        else if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    function automatic logic [31:0] alu_i(int rs, int rt, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'd0, 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] br(int rs, int tgt, int fn);
        return {6'd4, 5'(rs), 15'(tgt), 6'(fn)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input string name, input int i, input logic [31:0] exp);
        show_index = 5'(i);
        #1;
        chk(name, reg_return, exp);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 2048; i++) imem[i] = HALT_W;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // run to HALT within a cycle budget, watching dmem request stability
    task automatic run(input int budget, output int n);
        logic        prev;
        logic [43:0] pv;
        n = 0; dreq_n = 0; dbad = 0; unstable = 0; prev = 1'b0; pv = '0;
        while (!halted && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (dmem_req) begin
                dreq_n++;
                if (dmem_addr !== want_addr) dbad++;
                if (prev && {dmem_we, dmem_addr, dmem_wdata} !== pv) unstable++;
            end
            prev = dmem_req;
            pv = {dmem_we, dmem_addr, dmem_wdata};
        end
        chk("halt_reached", halted, 1'b1);
    endtask

    // ISA-level reference: executes imem from address 0 on fresh state
    logic [31:0] mrf [32];
    logic [31:0] mdm [2048];
    logic [31:0] mret;
    logic        mill;

    task automatic model();
        logic [31:0] pc, w, x, yv, r, ea, imm;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, sh;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        mdm = dm_init;
        mret = 0; mill = 0; pc = 0;
        for (int s = 0; s < 5000; s++) begin
            w = imem[pc[10:0]];
            op = w[31:26]; rs = w[25:21]; rt = w[20:16]; sh = w[10:6]; fn = w[5:0];
            x = mrf[rs]; yv = mrf[rt]; imm = {{16{w[15]}}, w[15:0]};
            ea = yv + imm;
            r = '0;
            if (op == 6'd0 && fn <= 6'd5) begin
                case (fn)
                    6'd0: r = x + yv;
                    6'd1: r = x - yv;
                    6'd2: r = x & yv;
                    6'd3: r = x ^ yv;
                    6'd4: r = x << sh;
                    default: r = $signed(x) >>> sh;
                endcase
                mrf[rs] = r; pc = pc + 1; mret++;
            end else if (op == 6'd1) begin
                mrf[rs] = x + imm; pc = pc + 1; mret++;
            end else if (op == 6'd2) begin
                mrf[rs] = mdm[ea[10:0]]; pc = pc + 1; mret++;
            end else if (op == 6'd3) begin
                mdm[ea[10:0]] = x; pc = pc + 1; mret++;
            end else if (op == 6'd4 && fn <= 6'd2) begin
                pc = (fn == 0 || (fn == 1 && x == 0) || (fn == 2 && $signed(x) < 0)) ? {17'd0, w[20:6]} : pc + 1;
                mret++;
            end else if (op == 6'h3f) begin
                mret++;
                break;
            end else begin
                mill = 1'b1;
                break;
            end
        end
    endtask

    task automatic gen_prog(input int n);
        int k, rs, rt, t;
        clear_imem();
        for (int i = 0; i < n - 1; i++) begin
            k = int'($urandom_range(0, 9)); rs = int'($urandom_range(0, 7)); rt = int'($urandom_range(0, 7));
            t = i + 1 + int'($urandom_range(0, 4));
            if (t > n - 1) t = n - 1;
            imem[i] = k <= 2 ? itype(6'd1, rs, rt, int'($urandom)) :
                      k <= 5 ? alu_i(rs, rt, int'($urandom_range(0, 31)), int'($urandom_range(0, 5))) :
                      k == 6 ? itype(6'd2, rs, rt, int'($urandom)) :
                      k == 7 ? itype(6'd3, rs, rt, int'($urandom)) :
                      k == 8 ? br(rs, t, int'($urandom_range(0, 2))) : itype(6'd1, rs, rt, int'($urandom_range(0, 9)));
        end
        imem[n - 1] = HALT_W;
    endtask

    typedef struct { logic [5:0] fn; logic [4:0] sh; logic [31:0] a, b, exp; } vec_t;
    typedef struct { int v; int fn; logic [10:0] exp; } bvec_t;

    // watchdog: the bench must never hang
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt [11];
        bvec_t bt [5];
        int    n, cnt, bad, np;
        vt[0]  = '{6'd0, 5'd0,  32'd5,          32'hFFFF_FFFD, 32'd2};
        vt[1]  = '{6'd0, 5'd0,  32'hFFFF_FFFF,  32'd1,         32'd0};
        vt[2]  = '{6'd1, 5'd0,  32'd3,          32'd5,         32'hFFFF_FFFE};
        vt[3]  = '{6'd1, 5'd0,  32'd0,          32'd1,         32'hFFFF_FFFF};
        vt[4]  = '{6'd2, 5'd0,  32'hF0F0_1234,  32'h0FF0_FF00, 32'h00F0_1200};
        vt[5]  = '{6'd3, 5'd0,  32'hF0F0_1234,  32'h0FF0_FF00, 32'hFF00_ED34};
        vt[6]  = '{6'd4, 5'd31, 32'd1,          32'd0,         32'h8000_0000};
        vt[7]  = '{6'd4, 5'd4,  32'h1234_5678,  32'd0,         32'h2345_6780};
        vt[8]  = '{6'd5, 5'd4,  32'h8000_0000,  32'd0,         32'hF800_0000};
        vt[9]  = '{6'd5, 5'd28, 32'h7000_0000,  32'd0,         32'd7};
        vt[10] = '{6'd5, 5'd0,  32'h8765_4321,  32'd0,         32'h8765_4321};
        bt[0] = '{1, 2, 11'd2};
        bt[1] = '{-1, 2, 11'd32};
        bt[2] = '{5, 1, 11'd2};
        bt[3] = '{0, 1, 11'd32};
        bt[4] = '{7, 0, 11'd32};
        for (int i = 0; i < 2048; i++) dm_init[i] = '0;

        // basic program at zero wait, including reset state and exact latency
        clear_imem();
        imem[0] = itype(6'd1, 1, 0, 5);
        imem[1] = itype(6'd1, 2, 0, -3);
        imem[2] = alu_i(1, 2, 0, 0);
        imem[3] = HALT_W;
        do_reset();
        chk("rst_halted", halted, 1'b0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_imem_req", imem_req, 1'b1);
        chk("rst_imem_addr", imem_addr, 11'd0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk_reg("rst_r1", 1, 32'd0);
        run(200, n);
        chk("seq1_cycles", n, 32'd15);
        chk_reg("seq1_r1", 1, 32'd2);
        chk_reg("seq1_r2", 2, 32'hFFFF_FFFD);
        chk("seq1_retired", retired, 32'd4);
        chk("seq1_halted", halted, 1'b1);

        // ALU vector table through lw-loaded operands
        imin = 0; imax = 2; dmin = 0; dmax = 2;
        for (int i = 0; i < 11; i++) begin
            clear_imem();
            imem[0] = itype(6'd2, 1, 0, 0);
            imem[1] = itype(6'd2, 2, 0, 1);
            imem[2] = alu_i(1, 2, int'(vt[i].sh), int'(vt[i].fn));
            imem[3] = HALT_W;
            dm_init[0] = vt[i].a; dm_init[1] = vt[i].b;
            do_reset();
            run(300, n);
            chk_reg($sformatf("vec%0d_r1", i), 1, vt[i].exp);
            chk_reg($sformatf("vec%0d_r2", i), 2, vt[i].b);
            chk($sformatf("vec%0d_retired", i), retired, 32'd4);
        end

        // sw then lw with a 3-cycle data memory
        imin = 0; imax = 0; dmin = 3; dmax = 3; want_addr = 11'd4;
        clear_imem();
        imem[0] = itype(6'd1, 1, 0, 32'h77);
        imem[1] = itype(6'd3, 1, 0, 4);
        imem[2] = itype(6'd2, 3, 0, 4);
        imem[3] = HALT_W;
        dm_init[4] = 32'hDEAD;
        do_reset();
        run(300, n);
        chk("mem_cycles", n, 32'd22);
        chk("mem_req_cycles", dreq_n, 32'd8);
        chk("mem_addr_off4", dbad, 32'd0);
        chk("mem_unstable", unstable, 32'd0);
        chk_reg("mem_r3", 3, 32'h77);
        chk("mem_dmem4", dmem[4], 32'h77);
        chk("mem_retired", retired, 32'd4);

        // bz r0 taken to 0x10
        dmin = 0; dmax = 0;
        clear_imem();
        imem[0] = br(0, 16, 1);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("bz_imem_addr", imem_addr, 11'h10);
        chk("bz_imem_req", imem_req, 1'b1);
        run(100, n);
        chk("bz_retired", retired, 32'd2);

        // branch outcome table: addi r1,v ; branch r1 to 0x20
        for (int i = 0; i < 5; i++) begin
            clear_imem();
            imem[0] = itype(6'd1, 1, 0, bt[i].v);
            imem[1] = br(1, 32, bt[i].fn);
            do_reset();
            repeat (7) @(posedge clk);
            #1;
            chk($sformatf("br%0d_imem_addr", i), imem_addr, bt[i].exp);
            run(100, n);
            chk($sformatf("br%0d_retired", i), retired, 32'd3);
        end

        // instruction fetch never acknowledged
        i_never = 1'b1;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) cnt++;
            @(posedge clk); #1;
        end
        i_never = 1'b0;
        chk("ito_req_cycles", cnt, 32'd15);
        chk("ito_bus_err", bus_err, 1'b1);
        chk("ito_halted", halted, 1'b1);
        chk("ito_illegal", illegal, 1'b0);
        chk("ito_retired", retired, 32'd0);

        // store never acknowledged: no write, bus error
        d_never = 1'b1;
        clear_imem();
        imem[0] = itype(6'd1, 1, 0, 9);
        imem[1] = itype(6'd3, 1, 0, 7);
        dm_init[7] = 32'h1234;
        want_addr = 11'd7;
        do_reset();
        run(200, n);
        d_never = 1'b0;
        chk("dto_bus_err", bus_err, 1'b1);
        chk("dto_req_cycles", dreq_n, 32'd15);
        chk("dto_dmem7", dmem[7], 32'h1234);
        chk("dto_retired", retired, 32'd1);

        // illegal opcode, ALU funct and branch funct
        for (int i = 0; i < 3; i++) begin
            clear_imem();
            imem[0] = itype(6'd1, 1, 0, 5);
            imem[1] = i == 0 ? 32'hA822_0007 : i == 1 ? alu_i(1, 1, 0, 6) : br(1, 0, 3);
            do_reset();
            run(100, n);
            chk($sformatf("ill%0d_illegal", i), illegal, 1'b1);
            chk($sformatf("ill%0d_bus_err", i), bus_err, 1'b0);
            chk($sformatf("ill%0d_retired", i), retired, 32'd1);
            chk_reg($sformatf("ill%0d_r1", i), 1, 32'd5);
            chk_reg($sformatf("ill%0d_r2", i), 2, 32'd0);
        end

        // reset pulse while a store waits for its ack
        d_never = 1'b1;
        clear_imem();
        imem[0] = itype(6'd1, 1, 0, 3);
        imem[1] = itype(6'd3, 1, 0, 5);
        do_reset();
        for (int i = 0; i < 50 && !dmem_req; i++) begin
            @(posedge clk); #1;
        end
        chk("rmem_reached", dmem_req, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rmem_dmem_req", dmem_req, 1'b0);
        chk("rmem_imem_addr", imem_addr, 11'd0);
        chk("rmem_retired", retired, 32'd0);
        chk_reg("rmem_r1", 1, 32'd0);
        rst = 1'b0;
        d_never = 1'b0;

        // random programs with random latencies against the ISA model
        imin = 0; imax = 3; dmin = 0; dmax = 3;
        for (int t = 0; t < 25; t++) begin
            np = int'($urandom_range(8, 40));
            gen_prog(np);
            for (int i = 0; i < 2048; i++) dm_init[i] = $urandom;
            do_reset();
            run(4000, n);
            model();
            for (int r = 0; r < 32; r++) chk_reg($sformatf("rnd%0d_r%0d", t, r), r, mrf[r]);
            chk($sformatf("rnd%0d_retired", t), retired, mret);
            chk($sformatf("rnd%0d_illegal", t), illegal, mill);
            chk($sformatf("rnd%0d_bus_err", t), bus_err, 1'b0);
            chk($sformatf("rnd%0d_unstable", t), unstable, 32'd0);
            bad = 0;
            for (int i = 0; i < 2048; i++) if (dmem[i] !== mdm[i]) bad++;
            chk($sformatf("rnd%0d_dmem_diffs", t), bad, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
